// File: rtl/pio_input_capture.sv
// Pushbutton/switch input capture: 2-FF sync, per-bit debounce, key-press edge
// capture with W1C/mask/IRQ, exposed over a fixed-latency Avalon-MM slave.
module pio_input_capture #(
  parameter int unsigned N_KEY           = 4,
  parameter int unsigned N_SW            = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEY-1:0]  key_n_in,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              irq,
  output logic [N_KEY-1:0]  key_level
);

  localparam int unsigned N_IN = N_KEY + N_SW;

  localparam logic [1:0] ADDR_KEY  = 2'd0;
  localparam logic [1:0] ADDR_SW   = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MASK = 2'd3;

  logic [N_IN-1:0]            sync1_q, sync1_d;
  logic [N_IN-1:0]            sync2_q, sync2_d;
  logic [N_IN-1:0]            stable_q, stable_d;
  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_KEY-1:0]           edge_q, edge_d;
  logic [N_KEY-1:0]           mask_q, mask_d;
  logic [N_KEY-1:0]           press_c;
  logic                       irq_q, irq_d;
  logic [31:0]                rdata_q, rdata_d;

  // Synchronizer inputs; keys are inverted on the way in so a cleared
  // synchronizer means "released" and a key held through reset still pays
  // the full sync + debounce latency.
  always_comb begin
    sync1_d = {sw_in, ~key_n_in};
    sync2_d = sync1_q;
  end

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Key presses (stable 0->1), edge W1C with set priority, mask and irq.
  always_comb begin
    press_c = stable_d[N_KEY-1:0] & ~stable_q[N_KEY-1:0];
    edge_d  = edge_q;
    mask_d  = mask_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_EDGE: edge_d = edge_q & ~N_KEY'(avs_writedata);
        ADDR_MASK: mask_d = N_KEY'(avs_writedata);
        default:   ;
      endcase
    end
    edge_d = edge_d | press_c;
    irq_d  = |(edge_q & mask_q);
  end

  // Read mux; readdata holds when no read is presented.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_KEY:  rdata_d = 32'(stable_q[N_KEY-1:0]);
        ADDR_SW:   rdata_d = 32'(stable_q[N_IN-1:N_KEY]);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;
  assign key_level    = stable_q[N_KEY-1:0];

endmodule

// File: tb/tb_pio_input_capture.sv
// Directed bench for pio_input_capture with a read-data scoreboard.
module tb_pio_input_capture;

  localparam int unsigned N_KEY = 4;
  localparam int unsigned N_SW  = 10;
  localparam int unsigned DB    = 4;
  localparam int unsigned LAT   = 2 + DB;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_KEY-1:0]  key_n_in;
  logic [N_SW-1:0]   sw_in;
  logic [1:0]        avs_address;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              irq;
  logic [N_KEY-1:0]  key_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  pio_input_capture #(
    .N_KEY(N_KEY), .N_SW(N_SW), .DEBOUNCE_CYCLES(DB), .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .key_n_in(key_n_in), .sw_in(sw_in),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq),
    .key_level(key_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted on a posedge is checked at the following negedge.
  always @(posedge clk) rd_seen <= avs_read;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_underflow: unexpected read data 0x%0h", avs_readdata);
      end else begin
        chk(name_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    avs_address = addr;
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick();
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  // Expect key_level[idx] to rise on exactly the n-th edge from now.
  task automatic wait_level(input int idx, input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == n - 1) chk({name, "_early"}, 32'(key_level[idx]), 32'd0);
      if (k == n)     chk({name, "_rise"},  32'(key_level[idx]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    key_n_in      = '1;
    sw_in         = '0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (3) tick();
    chk("rst_key_level", 32'(key_level), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset = 1'b0;
    repeat (8) tick();

    // 1: clean press of key 0, mask off
    key_n_in[0] = 1'b0;
    wait_level(0, LAT, "t1_key0");
    rd(2'd2, 32'h1, "t1_edge");
    chk("t1_irq", 32'(irq), 32'd0);
    key_n_in[0] = 1'b1;
    repeat (LAT + 2) tick();
    chk("t1_release", 32'(key_level[0]), 32'd0);
    rd(2'd2, 32'h1, "t1_edge_after_release");

    // 2: bouncing key 1 never settles until held
    for (int b = 0; b < 4; b++) begin
      key_n_in[1] = b[0];
      tick();
      chk("t2_bounce", 32'(key_level[1]), 32'd0);
    end
    key_n_in[1] = 1'b0;
    wait_level(1, LAT, "t2_key1");
    rd(2'd2, 32'h3, "t2_edge");
    key_n_in[1] = 1'b1;
    wr(2'd2, 32'hF);
    repeat (LAT + 2) tick();
    rd(2'd2, 32'h0, "t2_edge_clr");

    // 3: irq follows EDGE & MASK one cycle later
    wr(2'd3, 32'hF);
    chk("t3_irq_idle", 32'(irq), 32'd0);
    key_n_in[2] = 1'b0;
    wait_level(2, LAT, "t3_key2");
    chk("t3_irq_lag", 32'(irq), 32'd0);
    tick();
    chk("t3_irq_set", 32'(irq), 32'd1);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0, "t3_edge_clr");
    chk("t3_irq_clr", 32'(irq), 32'd0);
    key_n_in[2] = 1'b1;
    wr(2'd3, 32'h0);
    repeat (LAT + 2) tick();

    // 4: W1C on the same edge as a new press -> set wins
    key_n_in[3] = 1'b0;
    repeat (LAT - 1) tick();
    wr(2'd2, 32'h8);
    chk("t4_key3", 32'(key_level[3]), 32'd1);
    rd(2'd2, 32'h8, "t4_edge_set_wins");
    key_n_in[3] = 1'b1;
    repeat (LAT + 2) tick();
    rd(2'd2, 32'h8, "t4_release_no_edge");
    wr(2'd2, 32'hF);

    // 5: switches, RO write ignored, no edges from switches
    sw_in = 10'h2A5;
    repeat (LAT - 1) tick();
    rd(2'd1, 32'h0, "t5_sw_early");
    rd(2'd1, 32'h2A5, "t5_sw");
    rd(2'd2, 32'h0, "t5_edge");
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h0, "t5_key_ro");
    wr(2'd3, 32'h5);
    rd(2'd3, 32'h5, "t5_mask");

    // 6: reset in the middle of a debounce count
    key_n_in[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("t6_rdata", avs_readdata, 32'd0);
    chk("t6_key_level", 32'(key_level), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    tick();
    reset = 1'b0;
    wait_level(0, LAT, "t6_key0");
    rd(2'd2, 32'h1, "t6_edge");
    rd(2'd3, 32'h0, "t6_mask");
    rd(2'd1, 32'h2A5, "t6_sw");
    chk("t6_irq_masked", 32'(irq), 32'd0);

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
